rtn_addr_stack: RTL and testbench

Return-address stack for the 8-bit RISC core. Sits directly upstream of the program-counter block and drives its `return_addr` input. On a CALL the controller pushes the link address; on a RET it pops. The top entry is always presented so the PC can load it in the same cycle the pop is issued.

---
 rtl/rtn_addr_stack.sv | 183 ++++++++++++++++++
 tb/tb_rtn_addr_stack.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtn_addr_stack.sv
`default_nettype none
//==============================================================================
// Module   : rtn_addr_stack
// Purpose  : Return-address stack for the 8-bit RISC core. A CALL pushes the
//            link address and a RET pops it. The top entry is always presented
//            on return_addr, so the PC can load it on the same edge that
//            retires the pop.
//
// Parameters:
//   DEPTH  number of entries (power of two, 2..16)
//   AW     address width (matches the PC width)
//
// Ports:
//   clk          in   1              system clock, rising edge
//   reset        in   1              asynchronous reset, active low
//   push         in   1              store push_addr as the new top
//   pop          in   1              discard the current top
//   push_addr    in   AW             link address to store (PC+1 of the CALL)
//   clr_err      in   1              clear both sticky error flags
//   return_addr  out  AW             current top entry, 0 when empty
//   depth_cnt    out  clog2(DEPTH)+1 number of valid entries
//   empty        out  1              depth_cnt == 0
//   full         out  1              depth_cnt == DEPTH
//   ovfl_err     out  1              sticky: a push hit a full stack
//   unfl_err     out  1              sticky: a pop hit an empty stack
//
// Build option:
//   RTN_STACK_WRAP_EN  when defined, a push on a full stack overwrites the
//                      oldest entry; when undefined, that push is dropped.
//                      ovfl_err is set in both builds.
//
// Revision : 1.0  initial release
//==============================================================================
module rtn_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  input  logic                     clr_err,
  output logic [AW-1:0]            return_addr,
  output logic [$clog2(DEPTH):0]   depth_cnt,
  output logic                     empty,
  output logic                     full,
  output logic                     ovfl_err,
  output logic                     unfl_err
);

  // Index width and count width. The count needs one extra bit so that it
  // can represent DEPTH itself.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] TOS_ONE  = PW'(1);

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  // Entry storage is deliberately left without reset; an entry is only ever
  // observed after it has been written, because count gates return_addr.
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tos;
  logic [CW-1:0] count;
  logic          ovfl_q;
  logic          unfl_q;

  //--------------------------------------------------------------------------
  // Request decode (all from the registered state, never from outputs)
  //--------------------------------------------------------------------------
  logic          has_data;
  logic          is_full;
  logic          replace;     // push+pop on a non-empty stack
  logic          push_req;    // push that behaves as a plain push
  logic          pop_req;     // pop that actually removes an entry
  logic          push_adv;    // push that advances tos and writes tos+1
  logic          cnt_inc;     // push that grows the count
  logic          ovfl_evt;
  logic          unfl_evt;
  logic [PW-1:0] tos_inc;
  logic [PW-1:0] tos_dec;
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign has_data = (count != '0);
  assign is_full  = (count == FULL_CNT);

  // A simultaneous push and pop on a non-empty stack is a tail-call: the
  // top is replaced in place. On an empty stack there is nothing to pop,
  // so the pair degrades to a plain push and no underflow is reported.
  assign replace  = push & pop & has_data;
  assign push_req = push & ~replace;
  assign pop_req  = pop & ~push & has_data;
  assign unfl_evt = pop & ~push & ~has_data;
  assign ovfl_evt = push_req & is_full;

`ifdef RTN_STACK_WRAP_EN
  // Full push still advances tos; since tos wraps modulo DEPTH, tos+1 is
  // the slot of the oldest entry, which is overwritten. Count saturates.
  assign push_adv = push_req;
  assign cnt_inc  = push_req & ~is_full;
`else
  // Full push is dropped entirely: tos, count and storage all hold.
  assign push_adv = push_req & ~is_full;
  assign cnt_inc  = push_adv;
`endif

  // DEPTH is a power of two, so plain PW-bit arithmetic wraps modulo DEPTH.
  assign tos_inc = tos + TOS_ONE;
  assign tos_dec = tos - TOS_ONE;

  assign wr_en  = replace | push_adv;
  assign wr_idx = replace ? tos : tos_inc;

  //--------------------------------------------------------------------------
  // Storage write
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_addr;
    end
  end

  //--------------------------------------------------------------------------
  // Control and status registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos   <= '0;
      count <= '0;
    end else begin
      if (push_adv) begin
        tos <= tos_inc;
      end else if (pop_req) begin
        tos <= tos_dec;
      end

      if (cnt_inc) begin
        count <= count + CNT_ONE;
      end else if (pop_req) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Sticky error flags. A new error event takes priority over clr_err so an
  // event arriving in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovfl_q <= 1'b0;
      unfl_q <= 1'b0;
    end else begin
      if (ovfl_evt) begin
        ovfl_q <= 1'b1;
      end else if (clr_err) begin
        ovfl_q <= 1'b0;
      end

      if (unfl_evt) begin
        unfl_q <= 1'b1;
      end else if (clr_err) begin
        unfl_q <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs: pure functions of registers, no combinational path from
  // push/pop, so the PC sees a stable return address for the whole cycle.
  //--------------------------------------------------------------------------
  assign return_addr = has_data ? mem[tos] : '0;
  assign depth_cnt   = count;
  assign empty       = ~has_data;
  assign full        = is_full;
  assign ovfl_err    = ovfl_q;
  assign unfl_err    = unfl_q;

endmodule
`default_nettype wire

// File: tb/tb_rtn_addr_stack.sv
`default_nettype none
//==============================================================================
// Module   : tb_rtn_addr_stack
// Purpose  : Self-checking bench for rtn_addr_stack. A queue-based model of
//            the stack predicts every output; a negedge process compares the
//            DUT against it each cycle, and directed sequences pin the model
//            with literal expectations. Honors RTN_STACK_WRAP_EN like the DUT.
// Revision : 1.0  initial release
//==============================================================================
module tb_rtn_addr_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 8;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic          clr_err;
  logic [AW-1:0] return_addr;
  logic [3:0]    depth_cnt;
  logic          empty;
  logic          full;
  logic          ovfl_err;
  logic          unfl_err;

  rtn_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_addr   (push_addr),
    .clr_err     (clr_err),
    .return_addr (return_addr),
    .depth_cnt   (depth_cnt),
    .empty       (empty),
    .full        (full),
    .ovfl_err    (ovfl_err),
    .unfl_err    (unfl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Reference model: the queue holds valid entries oldest-first; back is top.
  logic [AW-1:0] q[$];
  bit m_ovfl = 1'b0;
  bit m_unfl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_ra();
    if (q.size() == 0) return '0;
    return q[q.size()-1];
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovfl = 1'b0;
    m_unfl = 1'b0;
  endtask

  task automatic model_step(input bit ps, input bit pp, input logic [AW-1:0] a, input bit cl);
    bit ov = 1'b0;
    bit un = 1'b0;
    if (ps && pp && q.size() > 0) begin
      q[q.size()-1] = a;
    end else if (ps) begin
      if (q.size() < DEPTH) begin
        q.push_back(a);
      end else begin
        ov = 1'b1;
`ifdef RTN_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(a);
`endif
      end
    end else if (pp) begin
      if (q.size() > 0) void'(q.pop_back());
      else un = 1'b1;
    end
    if (ov) m_ovfl = 1'b1; else if (cl) m_ovfl = 1'b0;
    if (un) m_unfl = 1'b1; else if (cl) m_unfl = 1'b0;
  endtask

  // One clock of stimulus: drive at posedge+1, model updates at the edge.
  task automatic cyc(input bit ps, input bit pp, input logic [AW-1:0] a, input bit cl);
    push      = ps;
    pop       = pp;
    push_addr = a;
    clr_err   = cl;
    @(posedge clk);
    model_step(ps, pp, a, cl);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("return_addr", return_addr, exp_ra());
      chk("depth_cnt",   depth_cnt,   q.size());
      chk("empty",       empty,       q.size() == 0);
      chk("full",        full,        q.size() == DEPTH);
      chk("ovfl_err",    ovfl_err,    m_ovfl);
      chk("unfl_err",    unfl_err,    m_unfl);
    end
  end

  logic [AW-1:0] exp_list [DEPTH];

  initial begin
    reset     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_addr = '0;
    clr_err   = 1'b0;
    model_reset();
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ra", return_addr, 8'h00);
    chk("rst_depth", depth_cnt, 0);
    chk("rst_ovfl", ovfl_err, 0);
    chk("rst_unfl", unfl_err, 0);

    // LIFO order; return_addr shows the entry being popped during the pop
    cyc(1, 0, 8'h10, 0);
    cyc(1, 0, 8'h20, 0);
    cyc(1, 0, 8'h30, 0);
    chk("lifo_top", return_addr, 8'h30);
    chk("lifo_depth3", depth_cnt, 3);
    cyc(0, 1, 8'h00, 0);
    chk("lifo_pop1", return_addr, 8'h20);
    cyc(0, 1, 8'h00, 0);
    chk("lifo_pop2", return_addr, 8'h10);
    cyc(0, 1, 8'h00, 0);
    chk("lifo_pop3", return_addr, 8'h00);
    chk("lifo_empty", empty, 1);

    // Fill to DEPTH then one extra push
    for (int i = 1; i <= 9; i++) cyc(1, 0, AW'(i), 0);
    chk("ovf_full", full, 1);
    chk("ovf_flag", ovfl_err, 1);
`ifdef RTN_STACK_WRAP_EN
    chk("ovf_top", return_addr, 8'h09);
    for (int i = 0; i < DEPTH; i++) exp_list[i] = AW'(9 - i);
`else
    chk("ovf_top", return_addr, 8'h08);
    for (int i = 0; i < DEPTH; i++) exp_list[i] = AW'(8 - i);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_pop_seq", return_addr, exp_list[i]);
      cyc(0, 1, 8'h00, 0);
    end
    chk("ovf_drained", empty, 1);
    cyc(0, 0, 8'h00, 1);
    chk("ovf_cleared", ovfl_err, 0);

    // Underflow and clear priority
    cyc(0, 1, 8'h00, 0);
    chk("unfl_set", unfl_err, 1);
    cyc(0, 1, 8'h00, 1);
    chk("unfl_set_wins", unfl_err, 1);
    cyc(0, 0, 8'h00, 1);
    chk("unfl_clr", unfl_err, 0);

    // Tail-call replace and push+pop on empty
    cyc(1, 0, 8'h40, 0);
    cyc(1, 1, 8'h55, 0);
    chk("repl_ra", return_addr, 8'h55);
    chk("repl_depth", depth_cnt, 1);
    cyc(0, 1, 8'h00, 0);
    cyc(1, 1, 8'h66, 0);
    chk("pp_empty_depth", depth_cnt, 1);
    chk("pp_empty_unfl", unfl_err, 0);
    chk("pp_empty_ra", return_addr, 8'h66);

    // Randomized traffic: a push-heavy phase then a pop-heavy phase
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
          AW'($urandom), $urandom_range(0, 99) < 8);
    end
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60,
          AW'($urandom), $urandom_range(0, 99) < 8);
    end

    // Asynchronous reset mid-cycle with three entries valid
    cyc(0, 0, 8'h00, 1);
    while (q.size() > 0) cyc(0, 1, 8'h00, 0);
    cyc(1, 0, 8'hA1, 0);
    cyc(1, 0, 8'hA2, 0);
    cyc(1, 0, 8'hA3, 0);
    chk("arst_pre_depth", depth_cnt, 3);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_ra", return_addr, 8'h00);
    chk("arst_depth", depth_cnt, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_after_empty", empty, 1);
    cyc(1, 0, 8'h77, 0);
    chk("arst_after_push", return_addr, 8'h77);

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
